sb_cache_arbiter: RTL and testbench
===================================

SB_CACHE_ARBITER -- requirements
Module: sb_cache_arbiter

Interface
REQ-001 Parameter ADDR_W, default `STOREBUFFER_LINE_SIZE, address width.
REQ-002 Parameter DATA_W, default `STOREBUFFER_LINE_SIZE, data width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive load grants allowed while store buffer non-empty.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ld_req  in  1  MEM-stage load request; held high until ld_done.
REQ-007 ld_addr  in  ADDR_W  load address, stable while ld_req high.
REQ-008 ld_done  out  1  one-cycle pulse, load transaction accepted by cache.
REQ-009 st_req  in  1  store attempting to enter store buffer this cycle.
REQ-010 sb_count  in  3  valid store buffer entries, 0..4.
REQ-011 sb_head_addr / sb_head_data  in  ADDR_W / DATA_W  oldest store buffer entry.
REQ-012 sb_pop  out  1  one-cycle pulse, dequeue oldest entry.
REQ-013 flush  in  1  one-cycle pulse, request complete drain (fence).
REQ-014 flush_done  out  1  one-cycle pulse, drain complete.
REQ-015 cache_req / cache_we  out  1 / 1  cache port request; we=1 write, 0 read.
REQ-016 cache_addr / cache_wdata  out  ADDR_W / DATA_W  cache port address/data, registered.
REQ-017 cache_ready  in  1  cache accepts request this cycle.
REQ-018 stall  out  1  pipeline stall to MEM stage.

Function
REQ-019 FSM states IDLE, LOAD, DRAIN; transaction completes on cycle with cache_req & cache_ready; completed state returns to IDLE next edge (one IDLE cycle between transactions).
REQ-020 IDLE priority, decided each cycle: (a) sb_count>0 and (sb_count==4 or flush_pending or starve_cnt==STARVE_MAX) -> DRAIN; (b) ld_req -> LOAD; (c) otherwise stay IDLE (see REQ-032).
REQ-021 On entering LOAD: latch cache_addr=ld_addr, cache_we=0; on entering DRAIN: latch cache_addr=sb_head_addr, cache_wdata=sb_head_data, cache_we=1.
REQ-022 cache_req high exactly while state is LOAD or DRAIN; cache_addr/cache_wdata/cache_we stable until completion.
REQ-023 ld_done = (state==LOAD) & cache_ready; sb_pop = (state==DRAIN) & cache_ready; never both high.
REQ-024 LOAD completes and pulses ld_done even if ld_req dropped mid-transaction.
REQ-025 starve_cnt (3 bits): +1 on each ld_done while sb_count>0, saturating at STARVE_MAX; cleared on sb_pop or when sb_count==0.
REQ-026 flush sets flush_pending; flush_pending clears and flush_done pulses in the first IDLE cycle with sb_count==0 (including cycle after flush when buffer already empty).
REQ-027 flush while flush_pending already set: ignored, single flush_done.
REQ-028 stall = (ld_req & ~ld_done) | flush_pending | (st_req & sb_count==4 & ~sb_pop).
REQ-029 Minimum load latency: ld_req in IDLE at cycle N with cache_ready tied 1 -> ld_done at N+1.

Reset
REQ-030 rst high at posedge: state=IDLE, cache_req=0, cache_we=0, cache_addr=0, cache_wdata=0, starve_cnt=0, flush_pending=0; ld_done, sb_pop, flush_done, stall=0 while rst high.
REQ-031 Reset mid-transaction abandons it: no ld_done, no sb_pop, store buffer entry not dequeued.

Configuration
REQ-032 Macro SB_IDLE_DRAIN_EN defined: IDLE with no ld_req and sb_count>0 enters DRAIN (opportunistic drain); undefined: drain only per REQ-020(a), buffer may hold entries indefinitely.

Verification
REQ-033 rst, then ld_req=1 ld_addr=0x40, sb_count=0, cache_ready=1 -> cache_req/we=0 addr=0x40 next cycle, ld_done 1 cycle, stall low after.
REQ-034 sb_count=4, ld_req=1 simultaneously in IDLE -> DRAIN first (cache_we=1, head addr/data), sb_pop, then LOAD; stall high until ld_done.
REQ-035 sb_count=2, ld_req held with back-to-back loads, macro undefined -> 4 ld_done, then forced DRAIN, sb_pop, starve_cnt=0.
REQ-036 flush with sb_count=3, cache_ready delayed 2 cycles each -> 3 sb_pop, flush_done one cycle after sb_count==0, stall high throughout.
REQ-037 rst asserted in DRAIN with cache_ready=0 -> next cycle cache_req=0, no sb_pop; with SB_IDLE_DRAIN_EN, sb_count=1 idle -> DRAIN entered without ld_req.

Source files
------------

// File: rtl/sb_cache_arbiter.sv
// Arbitrates the single cache port between MEM-stage loads and store-buffer drains.
// Define SB_IDLE_DRAIN_EN to drain the store buffer opportunistically when no load is waiting.
`ifndef STOREBUFFER_LINE_SIZE
`define STOREBUFFER_LINE_SIZE 32
`endif

module sb_cache_arbiter #(
  parameter int unsigned ADDR_W     = `STOREBUFFER_LINE_SIZE,
  parameter int unsigned DATA_W     = `STOREBUFFER_LINE_SIZE,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_done,
  input  logic              st_req,
  input  logic [2:0]        sb_count,
  input  logic [ADDR_W-1:0] sb_head_addr,
  input  logic [DATA_W-1:0] sb_head_data,
  output logic              sb_pop,
  input  logic              flush,
  output logic              flush_done,
  output logic              cache_req,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic              cache_ready,
  output logic              stall
);

  localparam int unsigned CNT_W      = 3;
  localparam logic [CNT_W-1:0] SB_FULL    = CNT_W'(4);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             flush_pending;
  logic             flush_pending_nxt;
  logic             sb_busy;
  logic             drain_due;

  assign sb_busy   = (sb_count != '0);
  assign drain_due = sb_busy && ((sb_count == SB_FULL) || flush_pending || (starve_cnt == STARVE_LIM));
  assign cache_req = (state != IDLE);

  // Next-state and handshake pulses; pulses are suppressed while reset is held.
  always_comb begin
    state_nxt  = state;
    ld_done    = 1'b0;
    sb_pop     = 1'b0;
    flush_done = 1'b0;
    unique case (state)
      IDLE: begin
        flush_done = flush_pending && !sb_busy;
        if (drain_due) begin
          state_nxt = DRAIN;
        end else if (ld_req) begin
          state_nxt = LOAD;
`ifdef SB_IDLE_DRAIN_EN
        end else if (sb_busy) begin
          state_nxt = DRAIN;
`endif
        end
      end
      LOAD: begin
        ld_done = cache_ready;
        if (cache_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        sb_pop = cache_ready;
        if (cache_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      ld_done    = 1'b0;
      sb_pop     = 1'b0;
      flush_done = 1'b0;
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = (ld_req && !ld_done) || flush_pending ||
              (st_req && (sb_count == SB_FULL) && !sb_pop);
    end
  end

  // Starvation counter saturates so a continuous load stream cannot block stores forever.
  always_comb begin
    starve_nxt = starve_cnt;
    if (sb_pop || !sb_busy) begin
      starve_nxt = '0;
    end else if (ld_done && (starve_cnt != STARVE_LIM)) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // A fence arriving while one is already outstanding merges into it.
  always_comb begin
    flush_pending_nxt = flush_pending;
    if (flush_done) begin
      flush_pending_nxt = 1'b0;
    end else if (flush) begin
      flush_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      flush_pending <= 1'b0;
      cache_we      <= 1'b0;
      cache_addr    <= '0;
      cache_wdata   <= '0;
    end else begin
      state         <= state_nxt;
      starve_cnt    <= starve_nxt;
      flush_pending <= flush_pending_nxt;
      if (state == IDLE && state_nxt == LOAD) begin
        cache_addr <= ld_addr;
        cache_we   <= 1'b0;
      end
      if (state == IDLE && state_nxt == DRAIN) begin
        cache_addr  <= sb_head_addr;
        cache_wdata <= sb_head_data;
        cache_we    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sb_cache_arbiter.sv
// Directed bench for sb_cache_arbiter: load path, forced drains, starvation limit, fences and reset.
// Most steps target the default build; the opportunistic-drain step follows SB_IDLE_DRAIN_EN.
module tb_sb_cache_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_done;
  logic              st_req;
  logic [2:0]        sb_count;
  logic [ADDR_W-1:0] sb_head_addr;
  logic [DATA_W-1:0] sb_head_data;
  logic              sb_pop;
  logic              flush;
  logic              flush_done;
  logic              cache_req;
  logic              cache_we;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_ready;
  logic              stall;

  int checks   = 0;
  int failures = 0;

  sb_cache_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_done      (ld_done),
    .st_req       (st_req),
    .sb_count     (sb_count),
    .sb_head_addr (sb_head_addr),
    .sb_head_data (sb_head_data),
    .sb_pop       (sb_pop),
    .flush        (flush),
    .flush_done   (flush_done),
    .cache_req    (cache_req),
    .cache_we     (cache_we),
    .cache_addr   (cache_addr),
    .cache_wdata  (cache_wdata),
    .cache_ready  (cache_ready),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ld_req = 1'b0; ld_addr = '0; st_req = 1'b0; sb_count = 3'd0;
    sb_head_addr = 32'h0000_0100; sb_head_data = 32'hDEAD_BEEF;
    flush = 1'b0; cache_ready = 1'b1;
    tick();
    ld_req = 1'b1;
    #1;
    // reset state, outputs quiet even with a pending load
    chk("rst_cache_req", 64'(cache_req), 64'd0);
    chk("rst_cache_we", 64'(cache_we), 64'd0);
    chk("rst_cache_addr", 64'(cache_addr), 64'd0);
    chk("rst_cache_wdata", 64'(cache_wdata), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ld_done", 64'(ld_done), 64'd0);

    // basic load, one-cycle latency
    tick();
    rst = 1'b0; ld_req = 1'b1; ld_addr = 32'h40;
    #1;
    chk("ld_idle_stall", 64'(stall), 64'd1);
    chk("ld_idle_req", 64'(cache_req), 64'd0);
    tick();
    chk("ld_cache_req", 64'(cache_req), 64'd1);
    chk("ld_cache_we", 64'(cache_we), 64'd0);
    chk("ld_cache_addr", 64'(cache_addr), 64'h40);
    chk("ld_done", 64'(ld_done), 64'd1);
    chk("ld_stall_done", 64'(stall), 64'd0);
    tick();
    ld_req = 1'b0;
    #1;
    chk("ld_after_req", 64'(cache_req), 64'd0);
    chk("ld_after_done", 64'(ld_done), 64'd0);
    chk("ld_after_stall", 64'(stall), 64'd0);

    // full buffer beats a simultaneous load
    sb_count = 3'd4; ld_req = 1'b1; ld_addr = 32'h80;
    #1;
    chk("full_idle_stall", 64'(stall), 64'd1);
    tick();
    chk("full_drain_req", 64'(cache_req), 64'd1);
    chk("full_drain_we", 64'(cache_we), 64'd1);
    chk("full_drain_addr", 64'(cache_addr), 64'h100);
    chk("full_drain_data", 64'(cache_wdata), 64'hDEAD_BEEF);
    chk("full_drain_pop", 64'(sb_pop), 64'd1);
    chk("full_drain_lddone", 64'(ld_done), 64'd0);
    chk("full_drain_stall", 64'(stall), 64'd1);
    tick();
    sb_count = 3'd3;
    #1;
    chk("full_gap_req", 64'(cache_req), 64'd0);
    chk("full_gap_stall", 64'(stall), 64'd1);
    tick();
    chk("full_load_we", 64'(cache_we), 64'd0);
    chk("full_load_addr", 64'(cache_addr), 64'h80);
    chk("full_load_done", 64'(ld_done), 64'd1);
    chk("full_load_stall", 64'(stall), 64'd0);
    tick();

    // store into full buffer stalls until the pop cycle
    ld_req = 1'b0; sb_count = 3'd4; st_req = 1'b1; cache_ready = 1'b0;
    #1;
    chk("st_full_stall_idle", 64'(stall), 64'd1);
    tick();
    chk("st_full_wait_pop", 64'(sb_pop), 64'd0);
    chk("st_full_wait_stall", 64'(stall), 64'd1);
    cache_ready = 1'b1;
    #1;
    chk("st_full_pop", 64'(sb_pop), 64'd1);
    chk("st_full_pop_stall", 64'(stall), 64'd0);
    tick();

    // starvation limit: four loads, then a forced drain
    st_req = 1'b0; sb_count = 3'd2; ld_req = 1'b1; ld_addr = 32'h200;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("starve_idle_req", 64'(cache_req), 64'd0);
      tick();
      chk("starve_ld_done", 64'(ld_done), 64'd1);
      chk("starve_ld_addr", 64'(cache_addr), 64'h200);
      tick();
    end
    chk("starve_gap_stall", 64'(stall), 64'd1);
    tick();
    chk("starve_drain_we", 64'(cache_we), 64'd1);
    chk("starve_drain_pop", 64'(sb_pop), 64'd1);
    chk("starve_drain_lddone", 64'(ld_done), 64'd0);
    tick();
    sb_count = 3'd1;
    #1;
    tick();
    chk("starve_cleared_load", 64'(cache_we), 64'd0);
    chk("starve_cleared_done", 64'(ld_done), 64'd1);
    tick();
    ld_req = 1'b0; sb_count = 3'd0;
    #1;

    // fence on an empty buffer completes in the following cycle
    flush = 1'b1;
    #1;
    chk("flush_empty_now", 64'(flush_done), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_empty_done", 64'(flush_done), 64'd1);
    chk("flush_empty_stall", 64'(stall), 64'd1);
    tick();
    chk("flush_empty_after", 64'(flush_done), 64'd0);
    chk("flush_empty_stall_after", 64'(stall), 64'd0);

    // fence with three entries and a slow cache; a second fence merges
    sb_count = 3'd3; flush = 1'b1; cache_ready = 1'b0;
    #1;
    chk("flush3_done_early", 64'(flush_done), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    for (int p = 0; p < 3; p++) begin
      int waited = 0;
      while (!cache_req && waited < 4) begin
        chk("flush3_wait_stall", 64'(stall), 64'd1);
        tick();
        waited++;
      end
      chk("flush3_drain_req", 64'(cache_req), 64'd1);
      chk("flush3_drain_we", 64'(cache_we), 64'd1);
      if (p == 0) flush = 1'b1;
      #1;
      chk("flush3_pop_wait1", 64'(sb_pop), 64'd0);
      chk("flush3_stall_wait1", 64'(stall), 64'd1);
      tick();
      flush = 1'b0;
      #1;
      chk("flush3_pop_wait2", 64'(sb_pop), 64'd0);
      tick();
      cache_ready = 1'b1;
      #1;
      chk("flush3_pop", 64'(sb_pop), 64'd1);
      chk("flush3_no_done", 64'(flush_done), 64'd0);
      chk("flush3_stall_pop", 64'(stall), 64'd1);
      tick();
      cache_ready = 1'b0;
      sb_count = sb_count - 3'd1;
      #1;
    end
    chk("flush3_done", 64'(flush_done), 64'd1);
    chk("flush3_done_stall", 64'(stall), 64'd1);
    tick();
    chk("flush3_single_done", 64'(flush_done), 64'd0);
    chk("flush3_stall_clear", 64'(stall), 64'd0);

    // reset mid-drain abandons the store
    sb_count = 3'd4;
    #1;
    tick();
    chk("rstd_drain_req", 64'(cache_req), 64'd1);
    chk("rstd_no_pop", 64'(sb_pop), 64'd0);
    rst = 1'b1; cache_ready = 1'b1; st_req = 1'b1; ld_req = 1'b1;
    #1;
    chk("rstd_pop_gated", 64'(sb_pop), 64'd0);
    chk("rstd_lddone_gated", 64'(ld_done), 64'd0);
    chk("rstd_stall_gated", 64'(stall), 64'd0);
    tick();
    chk("rstd_cache_req", 64'(cache_req), 64'd0);
    chk("rstd_cache_we", 64'(cache_we), 64'd0);
    chk("rstd_cache_addr", 64'(cache_addr), 64'd0);
    chk("rstd_cache_wdata", 64'(cache_wdata), 64'd0);
    rst = 1'b0; st_req = 1'b0; ld_req = 1'b0; sb_count = 3'd1;
    #1;
    chk("idle_hold_req0", 64'(cache_req), 64'd0);
    tick();
`ifdef SB_IDLE_DRAIN_EN
    chk("opp_drain_req", 64'(cache_req), 64'd1);
    chk("opp_drain_we", 64'(cache_we), 64'd1);
    chk("opp_drain_pop", 64'(sb_pop), 64'd1);
`else
    chk("idle_hold_req1", 64'(cache_req), 64'd0);
    tick();
    chk("idle_hold_req2", 64'(cache_req), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
